// File: rtl/step_sequencer_pc.sv
// Step counter for the multicycle controller: walks each instruction through fetch/decode/execute steps,
// raises Buff_PC on the class-specific last step, freezes on Stall, and parks in HALT until Resume.
module step_sequencer_pc #(
    parameter int CNT_W    = 3,
    parameter int RET_W    = 16,
    parameter int LAST_IMM = 2,
    parameter int LAST_ALU = 3,
    parameter int LAST_LD  = 4,
    parameter int LAST_ST  = 3,
    parameter int LAST_BR  = 2,
    parameter int LAST_JMP = 3,
    parameter int LAST_IO  = 2
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic [4:0]       InsM,
    input  logic [1:0]       InsL,
    input  logic             Stall,
    input  logic             Resume,
    output logic [CNT_W-1:0] Cnt,
    output logic             Buff_PC,
    output logic [2:0]       Ins_Class,
    output logic             Halted,
    output logic             Illegal,
    output logic [RET_W-1:0] Retired
);

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    localparam logic [2:0] C_IMM = 3'd0;
    localparam logic [2:0] C_ALU = 3'd1;
    localparam logic [2:0] C_LD  = 3'd2;
    localparam logic [2:0] C_ST  = 3'd3;
    localparam logic [2:0] C_BR  = 3'd4;
    localparam logic [2:0] C_JMP = 3'd5;
    localparam logic [2:0] C_IO  = 3'd6;
    localparam logic [2:0] C_HLT = 3'd7;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       cls_q, cls_d;
    logic             ill_q, ill_d;
    logic [RET_W-1:0] ret_q, ret_d;

    logic [2:0]       dec_cls;
    logic             dec_ill;
    logic [CNT_W-1:0] last_sel;
    logic             at_last;

    always_comb begin
        dec_cls = C_IO;
        dec_ill = 1'b0;
        case (InsM)
            5'b00000:                     dec_cls = C_ALU;
            5'b00001, 5'b00010:           dec_cls = C_IMM;
            5'b00011, 5'b00100:           dec_cls = C_LD;
            5'b00101:                     dec_cls = C_ST;
            5'b00110: begin
                if (InsL == 2'b00)        dec_cls = C_ST;
                else if (InsL == 2'b01)   dec_cls = C_ALU;
                else                      dec_ill = 1'b1;
            end
            5'b00111, 5'b01000, 5'b01011: dec_cls = C_ALU;
            5'b11000, 5'b11001:           dec_cls = C_BR;
            5'b10000, 5'b10001,
            5'b10010, 5'b10011:           dec_cls = C_JMP;
            5'b11100: begin
                if (InsL == 2'b00)        dec_cls = C_IO;
                else if (InsL == 2'b01)   dec_cls = C_HLT;
                else                      dec_ill = 1'b1;
            end
            default:                      dec_ill = 1'b1;
        endcase
    end

    always_comb begin
        last_sel = CNT_MAX;
        case (cls_q)
            C_IMM:   last_sel = CNT_W'(LAST_IMM);
            C_ALU:   last_sel = CNT_W'(LAST_ALU);
            C_LD:    last_sel = CNT_W'(LAST_LD);
            C_ST:    last_sel = CNT_W'(LAST_ST);
            C_BR:    last_sel = CNT_W'(LAST_BR);
            C_JMP:   last_sel = CNT_W'(LAST_JMP);
            C_IO:    last_sel = CNT_W'(LAST_IO);
            default: last_sel = CNT_MAX;
        endcase
    end

    // CNT_MAX term is the runaway guard: never let a step count spin past the top.
    assign at_last = (cnt_q >= CNT_W'(2)) && (cls_q != C_HLT) &&
                     ((cnt_q == last_sel) || (cnt_q == CNT_MAX));

    assign Buff_PC = (state_q == ST_HALT) ? Resume : (!Stall && at_last);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cls_d   = cls_q;
        ill_d   = 1'b0;
        ret_d   = ret_q + RET_W'(Buff_PC);
        if (state_q == ST_HALT) begin
            cnt_d = '0;
            if (Resume) state_d = ST_RUN;
        end else if (!Stall) begin
            if (cnt_q == '0) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q == CNT_W'(1)) begin
                cls_d = dec_cls;
                ill_d = dec_ill;
                cnt_d = CNT_W'(2);
            end else if (cls_q == C_HLT) begin
                state_d = ST_HALT;
                cnt_d   = '0;
            end else if (at_last) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            cls_q   <= C_IMM;
            ill_q   <= 1'b0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cls_q   <= cls_d;
            ill_q   <= ill_d;
            ret_q   <= ret_d;
        end
    end

    assign Cnt       = cnt_q;
    assign Ins_Class = cls_q;
    assign Halted    = (state_q == ST_HALT);
    assign Illegal   = ill_q;
    assign Retired   = ret_q;

endmodule

// File: tb/tb_step_sequencer_pc.sv
// Bench for step_sequencer_pc: directed instruction scenarios with literal expectations, then random traffic
// compared every cycle against an instruction-level reference model.
module tb_step_sequencer_pc;

    logic        clk = 1'b0;
    logic        Rst = 1'b0;
    logic [4:0]  InsM = '0;
    logic [1:0]  InsL = '0;
    logic        Stall = 1'b0;
    logic        Resume = 1'b0;
    logic [2:0]  Cnt;
    logic        Buff_PC;
    logic [2:0]  Ins_Class;
    logic        Halted;
    logic        Illegal;
    logic [15:0] Retired;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 0;

    step_sequencer_pc dut (
        .clk(clk), .Rst(Rst), .InsM(InsM), .InsL(InsL), .Stall(Stall), .Resume(Resume),
        .Cnt(Cnt), .Buff_PC(Buff_PC), .Ins_Class(Ins_Class), .Halted(Halted),
        .Illegal(Illegal), .Retired(Retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Last-step table indexed by class; HLT (7) never completes by step count.
    int last_of [8] = '{2, 3, 4, 3, 2, 3, 2, 99};
    int m_step = 0;   // step within the current instruction
    int m_cls  = 0;
    bit m_halt = 0;
    bit m_ill  = 0;
    int m_ret  = 0;

    function automatic void model_dec(input logic [4:0] m, input logic [1:0] l,
                                      output int c, output bit il);
        int v = int'(m);
        il = 0;
        c  = 6;
        if (v == 0 || v == 7 || v == 8 || v == 11) c = 1;
        else if (v == 1 || v == 2)                 c = 0;
        else if (v == 3 || v == 4)                 c = 2;
        else if (v == 5)                           c = 3;
        else if (v == 24 || v == 25)               c = 4;
        else if (v >= 16 && v <= 19)               c = 5;
        else if (v == 6 && l == 2'd0)              c = 3;
        else if (v == 6 && l == 2'd1)              c = 1;
        else if (v == 28 && l == 2'd0)             c = 6;
        else if (v == 28 && l == 2'd1)             c = 7;
        else                                       il = 1;
    endfunction

    // PC advances when the instruction has spent exactly last_of+1 steps, or on resume from HALT.
    function automatic bit model_pc();
        if (!Rst)  return 0;
        if (m_halt) return Resume;
        if (Stall || m_step < 2 || m_cls == 7) return 0;
        return (m_step == last_of[m_cls]) || (m_step == 7);
    endfunction

    always @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            m_step = 0; m_cls = 0; m_halt = 0; m_ill = 0; m_ret = 0;
        end else begin
            bit pc;
            pc    = model_pc();
            m_ill = 0;
            if (pc) m_ret = (m_ret + 1) % 65536;
            if (m_halt) begin
                if (Resume) m_halt = 0;
            end else if (!Stall) begin
                if (m_step == 1) begin
                    int c; bit il;
                    model_dec(InsM, InsL, c, il);
                    m_cls = c; m_ill = il; m_step = 2;
                end else if (m_step >= 2 && m_cls == 7) begin
                    m_halt = 1; m_step = 0;
                end else if (pc) begin
                    m_step = 0;
                end else begin
                    m_step = m_step + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_cnt",     Cnt,       m_halt ? 0 : m_step);
            chk("m_buff_pc", Buff_PC,   model_pc());
            chk("m_class",   Ins_Class, m_cls);
            chk("m_halted",  Halted,    m_halt);
            chk("m_illegal", Illegal,   m_ill);
            chk("m_retired", Retired,   m_ret);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic reset_dut();
        Rst = 1'b0; Stall = 1'b0; Resume = 1'b0;
        repeat (2) @(posedge clk);
        #1 Rst = 1'b1;
    endtask

    // Runs one instruction from Cnt=0 until Buff_PC, optionally stalling st_len cycles at step st_at.
    task automatic do_instr(input logic [4:0] m, input logic [1:0] l, input int st_at, input int st_len,
                            output int pc_cnt, output int cycles, output int ill_n, output int cls);
        int stalled = 0;
        bit done = 0;
        pc_cnt = -1; cycles = 0; ill_n = 0; cls = -1;
        InsM = m; InsL = l;
        while (!done && cycles < 40) begin
            Stall = (int'(Cnt) == st_at) && (stalled < st_len);
            if (Stall) stalled++;
            @(negedge clk);
            cycles++;
            if (Illegal) ill_n++;
            if (Buff_PC) begin
                pc_cnt = int'(Cnt); cls = int'(Ins_Class); done = 1;
            end
            @(posedge clk); #1;
        end
        Stall = 1'b0;
        chk("instr_completes", done, 1);
    endtask

    initial begin
        int pc, cyc, il, cl;

        @(posedge clk); #1;
        reset_dut();
        cmp_en = 1;
        chk("rst_cnt", Cnt, 0);
        chk("rst_retired", Retired, 0);
        chk("rst_halted", Halted, 0);

        // ADD
        do_instr(5'b00000, 2'b00, -1, 0, pc, cyc, il, cl);
        chk("add_pc_cnt", pc, 3);
        chk("add_cycles", cyc, 4);
        chk("add_cnt_after", Cnt, 0);
        chk("add_retired", Retired, 1);

        // LDRri, LHI, BAL, JR
        reset_dut();
        do_instr(5'b00011, 2'b00, -1, 0, pc, cyc, il, cl);
        chk("ldr_pc_cnt", pc, 4);
        do_instr(5'b00001, 2'b00, -1, 0, pc, cyc, il, cl);
        chk("lhi_pc_cnt", pc, 2);
        do_instr(5'b11001, 2'b00, -1, 0, pc, cyc, il, cl);
        chk("bal_pc_cnt", pc, 2);
        chk("bal_class", cl, 4);
        do_instr(5'b10011, 2'b00, -1, 0, pc, cyc, il, cl);
        chk("jr_pc_cnt", pc, 3);
        chk("seq_retired", Retired, 4);

        // STRrr vs CMP share InsM
        do_instr(5'b00110, 2'b00, -1, 0, pc, cyc, il, cl);
        chk("strrr_class", cl, 3);
        chk("strrr_pc_cnt", pc, 3);
        do_instr(5'b00110, 2'b01, -1, 0, pc, cyc, il, cl);
        chk("cmp_class", cl, 1);
        chk("cmp_pc_cnt", pc, 3);

        // LDRrr stalled 3 cycles at its last step
        do_instr(5'b00100, 2'b00, 4, 3, pc, cyc, il, cl);
        chk("ldstall_pc_cnt", pc, 4);
        chk("ldstall_cycles", cyc, 8);

        // HLT then resume
        InsM = 5'b11100; InsL = 2'b01;
        repeat (3) begin
            @(negedge clk);
            chk("hlt_no_pc", Buff_PC, 0);
            @(posedge clk); #1;
        end
        Stall = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("halt_flag", Halted, 1);
            chk("halt_cnt", Cnt, 0);
            chk("halt_class", Ins_Class, 7);
            @(posedge clk); #1;
        end
        Stall = 1'b0; Resume = 1'b1;
        @(negedge clk);
        chk("resume_pc", Buff_PC, 1);
        @(posedge clk); #1;
        Resume = 1'b0; InsM = 5'b00000; InsL = 2'b00;
        @(negedge clk);
        chk("resume_cnt0", Cnt, 0);
        chk("resume_unhalted", Halted, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("resume_cnt1", Cnt, 1);
        @(posedge clk); #1;
        do_instr(5'b00000, 2'b00, -1, 0, pc, cyc, il, cl);
        chk("post_resume_add_pc", pc, 3);

        // Illegal opcode
        do_instr(5'b11111, 2'b00, -1, 0, pc, cyc, il, cl);
        chk("illegal_pulses", il, 1);
        chk("illegal_pc_cnt", pc, 2);
        chk("illegal_class", cl, 6);

        // Asynchronous reset mid-LDRri
        InsM = 5'b00011; InsL = 2'b00;
        repeat (3) @(posedge clk);
        #1 chk("pre_rst_cnt", Cnt, 3);
        #1 Rst = 1'b0;
        #1;
        chk("async_rst_cnt", Cnt, 0);
        chk("async_rst_retired", Retired, 0);
        chk("async_rst_pc", Buff_PC, 0);
        @(posedge clk); #1 Rst = 1'b1;

        // Asynchronous reset while halted
        InsM = 5'b11100; InsL = 2'b01;
        repeat (4) @(posedge clk);
        #1 chk("pre_rst_halted", Halted, 1);
        #1 Rst = 1'b0;
        #1 chk("async_rst_halted", Halted, 0);
        @(posedge clk); #1 Rst = 1'b1;

        // Random traffic
        begin
            logic [4:0] legal [14] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                                       5'd8, 5'd11, 5'd24, 5'd16, 5'd19, 5'd28};
            for (int i = 0; i < 4000; i++) begin
                InsM   = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 13)] : 5'($urandom);
                InsL   = 2'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : $urandom_range(0, 1));
                Stall  = ($urandom_range(0, 4) == 0);
                Resume = ($urandom_range(0, 3) == 0);
                Rst    = ($urandom_range(0, 499) != 0);
                @(posedge clk); #1;
            end
            Rst = 1'b1; Stall = 1'b0; Resume = 1'b0;
            repeat (2) @(posedge clk);
        end

        @(negedge clk);
        cmp_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/step_sequencer_pc.md
Name: step_sequencer_pc

Overview:
Parametrised successor to the fixed Buff_PC decoder in the multicycle RISC controller. It owns the step counter Cnt, latches the opcode class at the decode step, and asserts Buff_PC (PC advance) on the last step of each instruction class. It adds per-class programmable step counts, a memory-stall freeze, a HLT/resume state and a retired-instruction counter. It sits between the instruction register and the PC/control-signal decoders.

Parameters:
CNT_W, 3, width of Cnt
RET_W, 16, width of retired-instruction counter
LAST_IMM, 2, last step of LHI/LLI
LAST_ALU, 3, last step of ADD/ADC/SUB/SBB/CMP/ADDI/SUBI/MOV
LAST_LD, 4, last step of LDRri/LDRrr
LAST_ST, 3, last step of STRri/STRrr
LAST_BR, 2, last step of Bcc/BAL
LAST_JMP, 3, last step of JMP/JALrl/JALrr/JR
LAST_IO, 2, last step of OutR and of illegal opcodes
Constraint: every LAST_* is in 2..2^CNT_W-1.

Ports:
clk  in  1  clock, rising edge
Rst  in  1  asynchronous, active-low reset
InsM  in  5  instruction bits [15:11]
InsL  in  2  instruction bits [1:0]
Stall  in  1  memory wait; freezes sequencing
Resume  in  1  leave HALT
Cnt  out  CNT_W  current step (0 = fetch, 1 = decode)
Buff_PC  out  1  PC load enable (combinational from registered state)
Ins_Class  out  3  latched class: 0 IMM, 1 ALU, 2 LD, 3 ST, 4 BR, 5 JMP, 6 IO, 7 HLT
Halted  out  1  high in HALT
Illegal  out  1  one-cycle pulse, illegal opcode decoded
Retired  out  RET_W  count of Buff_PC pulses

Behaviour:
- Reset (Rst=0, asynchronous): Cnt=0, state RUN, Ins_Class=0, Halted=0, Illegal=0, Retired=0. Buff_PC=0 while Rst=0. Reset takes effect mid-instruction with no completion.
- Decode map (InsM, InsL):
  - 00000 -> ALU
  - 00001, 00010 -> IMM
  - 00011, 00100 -> LD
  - 00101 -> ST
  - 00110 with InsL=00 -> ST; 00110 with InsL=01 -> ALU
  - 00111, 01000, 01011 -> ALU
  - 11000, 11001 -> BR
  - 10000..10011 -> JMP
  - 11100 with InsL=00 -> IO; 11100 with InsL=01 -> HLT
  - Everything else (including 00110/11100 with InsL=1x) -> IO with Illegal=1.
- RUN sequencing, Stall=0:
  - Cnt=0: next Cnt=1.
  - Cnt=1: decode live InsM/InsL, register Ins_Class; next Cnt=2. Illegal registers 1 for exactly that one following cycle.
  - Cnt>=2: compare Cnt to LAST of Ins_Class. On match, Buff_PC=1 and next Cnt=0. Otherwise next Cnt=Cnt+1.
  - HLT: at Cnt=2, Buff_PC=0, next state HALT, Cnt=0.
- Stall=1 in RUN: Cnt, Ins_Class and Retired hold; Buff_PC forced 0. A pending last step completes on the first cycle Stall=0.
- HALT: Cnt=0, Halted=1, Stall ignored.
  - Resume=0: stay in HALT.
  - Resume=1: Buff_PC=1 that cycle (PC steps past HLT), next state RUN, Cnt=0, Halted=0.
- Retired increments on every clock edge where Buff_PC=1. It wraps modulo 2^RET_W.
- Safety: if Cnt reaches 2^CNT_W-1 without a match, assert Buff_PC and wrap Cnt to 0.
- Latency: instruction of class K takes LAST_K+1 cycles from Cnt=0 to Cnt=0, plus stall cycles.

Test Plan:
- Reset then ADD (InsM=00000, InsL=00): Cnt 0,1,2,3; Buff_PC=1 only at Cnt=3; Cnt=0 next; Retired=1.
- Sequence LDRri (00011), LHI (00001), BAL (11001), JR (10011): Buff_PC at Cnt 4, 2, 2, 3 respectively; Retired=4.
- STRrr (00110/00) vs CMP (00110/01): Ins_Class=3, Buff_PC at Cnt 3; then Ins_Class=1, Buff_PC at Cnt 3.
- LDRrr with Stall=1 for 3 cycles at Cnt=4: Cnt holds 4, Buff_PC=0; Buff_PC=1 on first cycle after Stall drops; total 8 cycles.
- HLT (11100/01): no Buff_PC at Cnt=2, Halted=1 with Cnt=0 for 5 idle cycles; Resume pulse gives Buff_PC=1 for one cycle, then Cnt 0,1 resumes.
- InsM=11111 gives Illegal pulse of 1 cycle and Buff_PC at Cnt 2. Rst driven low at Cnt=3 of LDRri clears Cnt, Retired and Halted immediately, without waiting for a clock edge.
